serial_mem_responder: RTL
=========================

SERIAL_MEM_RESPONDER -- requirements
Module: serial_mem_responder

Interface
REQ-001: Parameter ADDR_BITS, default 64, width of mem_req_addr; valid range 32..64; upper header address bits beyond ADDR_BITS are discarded.
REQ-002: clock  input  1  sole clock; all state updates on posedge.
REQ-003: reset  input  1  synchronous, active-high reset.
REQ-004: serial_in_valid  input  1  host-to-target word valid.
REQ-005: serial_in_ready  output  1  responder accepts serial_in_bits this cycle.
REQ-006: serial_in_bits  input  32  host-to-target word.
REQ-007: serial_out_valid  output  1  target-to-host read-data word valid.
REQ-008: serial_out_ready  input  1  host accepts serial_out_bits.
REQ-009: serial_out_bits  output  32  read-data word.
REQ-010: mem_req_valid  output  1  memory request valid.
REQ-011: mem_req_ready  input  1  memory accepts request.
REQ-012: mem_req_write  output  1  1 = write, 0 = read.
REQ-013: mem_req_addr  output  ADDR_BITS  byte address of the 32-bit word.
REQ-014: mem_req_data  output  32  write data; don't-care on reads.
REQ-015: mem_resp_valid  input  1  memory response valid; one per request, reads and writes alike.
REQ-016: mem_resp_ready  output  1  responder accepts the response.
REQ-017: mem_resp_data  input  32  read data; ignored for writes.
REQ-018: busy  output  1  high in any state other than CMD.
REQ-019: bad_cmd  output  1  sticky flag; set on unknown command.

Function
REQ-020: Transfers complete on valid&&ready at posedge; every output is registered.
REQ-021: Packet format, one 32-bit word each: cmd, addr_lo, addr_hi, len_lo, len_hi; then for writes, len+1 data words. cmd 0 = read, cmd 1 = write.
REQ-022: FSM states: CMD, ADDR_LO, ADDR_HI, LEN_LO, LEN_HI, WDATA, WREQ, WRESP, RREQ, RRESP, RSEND.
REQ-023: serial_in_ready is high only in the states CMD, ADDR_LO, ADDR_HI, LEN_LO, LEN_HI and WDATA.
REQ-024: Each header state advances to the next header state when it accepts a word.
- LEN_HI goes to WDATA when cmd == 1.
- LEN_HI goes to RREQ when cmd == 0.
REQ-025: When cmd > 1, LEN_HI returns to CMD instead.
- bad_cmd is set; no memory request is issued; no data words are consumed.
REQ-026: Write path.
- WDATA latches the accepted word and goes to WREQ.
- WREQ holds mem_req_valid=1, mem_req_write=1 until mem_req_ready, then goes to WRESP.
- WRESP holds mem_resp_ready=1 until mem_resp_valid.
REQ-027: Read path.
- RREQ issues mem_req_write=0 until mem_req_ready, then goes to RRESP.
- RRESP latches mem_resp_data into serial_out_bits and goes to RSEND.
- RSEND holds serial_out_valid=1 until serial_out_ready.
REQ-028: At most one memory request is outstanding; mem_req_valid and serial_out_valid are never high together.
REQ-029: Address for word n = {addr_hi,addr_lo} + 4*n, truncated to ADDR_BITS; it wraps modulo 2^ADDR_BITS with no error.
REQ-030: Word counter.
- The counter is 64-bit and is loaded with {len_hi,len_lo}.
- After a word completes (WRESP handshake, or RSEND handshake), the next state is CMD when the counter is 0.
- Otherwise the counter decrements, the address advances, and the next state is WDATA or RREQ.
REQ-031: len = 0 transfers exactly one word; len = 0xFFFFFFFF_FFFFFFFF is legal and runs indefinitely.
REQ-032: Minimum latency from data word accept to mem_req_valid is 1 cycle.
REQ-033: Minimum latency from mem_resp handshake to serial_out_valid is 1 cycle.
REQ-034: mem_resp_valid outside WRESP/RRESP is not accepted (mem_resp_ready=0).

Reset
REQ-035: Reset state is CMD.
REQ-036: On reset: serial_in_ready=0 during the reset cycle, then 1.
- serial_out_valid=0, mem_req_valid=0, mem_resp_ready=0, busy=0, bad_cmd=0.
- serial_out_bits, mem_req_addr and mem_req_data are 0.
REQ-037: Reset mid-packet abandons the transfer immediately.
- Any outstanding memory response is not waited for.
- The next accepted word is treated as cmd.

Verification
REQ-038: Write 1 word: host sends 1,0x1000,0,0,0,0xDEADBEEF -> one mem_req (write=1, addr=0x1000, data=0xDEADBEEF); after the resp, state is CMD and busy=0.
REQ-039: Read 3 words: host sends 0,0x2000,0,2,0; memory returns A,B,C -> req addrs 0x2000/0x2004/0x2008; serial_out emits A,B,C in order.
REQ-040: Backpressure: during a read, hold serial_out_ready=0 for 10 cycles -> serial_out_valid and serial_out_bits stay stable; no new mem_req is issued.
REQ-041: Wrap: write with addr 0xFFFFFFFF_FFFFFFFC, len=1 -> addrs ...FFFC, then 0x0.
REQ-042: Bad command: cmd=7 with any header -> bad_cmd=1, no mem_req; next packet is processed normally.
REQ-043: Reset after addr_lo of a write -> CMD state; a following read packet behaves per REQ-039.

Source files
------------

// File: rtl/serial_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : serial_mem_responder
// Description : Decodes a 32-bit serial packet stream into word-wide memory
//               reads/writes, returning read data on the serial output.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_mem_responder #(
    parameter int ADDR_BITS = 64
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 serial_in_valid,
    output logic                 serial_in_ready,
    input  logic [31:0]          serial_in_bits,
    output logic                 serial_out_valid,
    input  logic                 serial_out_ready,
    output logic [31:0]          serial_out_bits,
    output logic                 mem_req_valid,
    input  logic                 mem_req_ready,
    output logic                 mem_req_write,
    output logic [ADDR_BITS-1:0] mem_req_addr,
    output logic [31:0]          mem_req_data,
    input  logic                 mem_resp_valid,
    output logic                 mem_resp_ready,
    input  logic [31:0]          mem_resp_data,
    output logic                 busy,
    output logic                 bad_cmd
);

    localparam logic [3:0] S_CMD     = 4'd0;
    localparam logic [3:0] S_ADDR_LO = 4'd1;
    localparam logic [3:0] S_ADDR_HI = 4'd2;
    localparam logic [3:0] S_LEN_LO  = 4'd3;
    localparam logic [3:0] S_LEN_HI  = 4'd4;
    localparam logic [3:0] S_WDATA   = 4'd5;
    localparam logic [3:0] S_WREQ    = 4'd6;
    localparam logic [3:0] S_WRESP   = 4'd7;
    localparam logic [3:0] S_RREQ    = 4'd8;
    localparam logic [3:0] S_RRESP   = 4'd9;
    localparam logic [3:0] S_RSEND   = 4'd10;

    localparam logic [ADDR_BITS-1:0] ADDR_STEP = ADDR_BITS'(4);

    logic [3:0]           state_q, state_d;
    logic [31:0]          cmd_q, cmd_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic [63:0]          cnt_q, cnt_d;
    logic [31:0]          wdata_q, wdata_d;
    logic [31:0]          rdata_q, rdata_d;
    logic                 bad_q, bad_d;
    logic                 in_ready_q, out_valid_q, req_valid_q, req_write_q;
    logic                 resp_ready_q, busy_q;

    logic                 w_in_fire, w_req_fire, w_resp_fire, w_out_fire;
    logic [ADDR_BITS-1:0] w_addr_lo_set, w_addr_hi_set;

    assign w_in_fire   = serial_in_valid & in_ready_q;
    assign w_req_fire  = req_valid_q & mem_req_ready;
    assign w_resp_fire = resp_ready_q & mem_resp_valid;
    assign w_out_fire  = out_valid_q & serial_out_ready;

    // Header address bits above ADDR_BITS are dropped when the address is narrow.
    generate
        if (ADDR_BITS > 32) begin : g_addr_wide
            assign w_addr_lo_set = {addr_q[ADDR_BITS-1:32], serial_in_bits};
            assign w_addr_hi_set = {serial_in_bits[ADDR_BITS-33:0], addr_q[31:0]};
        end else begin : g_addr_narrow
            assign w_addr_lo_set = serial_in_bits;
            assign w_addr_hi_set = addr_q;
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        bad_d   = bad_q;
        case (state_q)
            S_CMD: if (w_in_fire) begin
                cmd_d   = serial_in_bits;
                state_d = S_ADDR_LO;
            end
            S_ADDR_LO: if (w_in_fire) begin
                addr_d  = w_addr_lo_set;
                state_d = S_ADDR_HI;
            end
            S_ADDR_HI: if (w_in_fire) begin
                addr_d  = w_addr_hi_set;
                state_d = S_LEN_LO;
            end
            S_LEN_LO: if (w_in_fire) begin
                cnt_d   = {cnt_q[63:32], serial_in_bits};
                state_d = S_LEN_HI;
            end
            S_LEN_HI: if (w_in_fire) begin
                cnt_d = {serial_in_bits, cnt_q[31:0]};
                if (|cmd_q[31:1]) begin
                    bad_d   = 1'b1;
                    state_d = S_CMD;
                end else begin
                    state_d = cmd_q[0] ? S_WDATA : S_RREQ;
                end
            end
            S_WDATA: if (w_in_fire) begin
                wdata_d = serial_in_bits;
                state_d = S_WREQ;
            end
            S_WREQ:  if (w_req_fire) state_d = S_WRESP;
            S_RREQ:  if (w_req_fire) state_d = S_RRESP;
            S_RRESP: if (w_resp_fire) begin
                rdata_d = mem_resp_data;
                state_d = S_RSEND;
            end
            S_WRESP, S_RSEND: begin
                // A word finishes on the write response or the read-data handoff.
                if ((state_q == S_WRESP) ? w_resp_fire : w_out_fire) begin
                    if (cnt_q == 64'd0) begin
                        state_d = S_CMD;
                    end else begin
                        cnt_d   = cnt_q - 64'd1;
                        addr_d  = addr_q + ADDR_STEP;
                        state_d = (state_q == S_WRESP) ? S_WDATA : S_RREQ;
                    end
                end
            end
            default: state_d = S_CMD;
        endcase
    end

    // Handshake outputs are registered copies of the next-state decode.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_CMD;
            cmd_q        <= '0;
            addr_q       <= '0;
            cnt_q        <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            bad_q        <= 1'b0;
            in_ready_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            req_valid_q  <= 1'b0;
            req_write_q  <= 1'b0;
            resp_ready_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cmd_q        <= cmd_d;
            addr_q       <= addr_d;
            cnt_q        <= cnt_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
            bad_q        <= bad_d;
            in_ready_q   <= (state_d <= S_WDATA);
            out_valid_q  <= (state_d == S_RSEND);
            req_valid_q  <= (state_d == S_WREQ) || (state_d == S_RREQ);
            req_write_q  <= (state_d == S_WREQ);
            resp_ready_q <= (state_d == S_WRESP) || (state_d == S_RRESP);
            busy_q       <= (state_d != S_CMD);
        end
    end

    assign serial_in_ready  = in_ready_q;
    assign serial_out_valid = out_valid_q;
    assign serial_out_bits  = rdata_q;
    assign mem_req_valid    = req_valid_q;
    assign mem_req_write    = req_write_q;
    assign mem_req_addr     = addr_q;
    assign mem_req_data     = wdata_q;
    assign mem_resp_ready   = resp_ready_q;
    assign busy             = busy_q;
    assign bad_cmd          = bad_q;

endmodule
`default_nettype wire
